// File: rtl/axi_slave_pkg.sv
// ============================================================================
// Module      : axi_slave_pkg
// Description : Shared definitions for the AXI4-Lite accelerator control
//               slave: register word indices, response code, FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_slave_pkg;

  // Word indices (byte address bits [AXIS_ADDR_WIDTH-1:2])
  localparam int REG_CTRL    = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_IRQ     = 2;
  localparam int REG_TOT_CYC = 4;
  localparam int REG_RD_CYC  = 5;
  localparam int REG_PR_CYC  = 6;
  localparam int REG_WR_CYC  = 7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_slave_rd_mux.sv
// ============================================================================
// Module      : axi_slave_rd_mux
// Description : Combinational read-data selector: word index -> 32-bit value.
//               Perf counters are zero-extended or truncated to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_slave_rd_mux
  import axi_slave_pkg::*;
#(
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int IDX_W           = 4
) (
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [31:0]                ctrl_i,
  input  logic [3:0]                 status_i,
  input  logic                       irq_pend_i,
  input  logic [PERF_CNTR_WIDTH-1:0] total_cycles_i,
  input  logic [PERF_CNTR_WIDTH-1:0] rd_cycles_i,
  input  logic [PERF_CNTR_WIDTH-1:0] pr_cycles_i,
  input  logic [PERF_CNTR_WIDTH-1:0] wr_cycles_i,
  output logic [31:0]                rdata_o
);

  logic [31:0] tot_ext;
  logic [31:0] rd_ext;
  logic [31:0] pr_ext;
  logic [31:0] wr_ext;

  generate
    if (PERF_CNTR_WIDTH >= 32) begin : g_trunc
      assign tot_ext = total_cycles_i[31:0];
      assign rd_ext  = rd_cycles_i[31:0];
      assign pr_ext  = pr_cycles_i[31:0];
      assign wr_ext  = wr_cycles_i[31:0];
    end else begin : g_zext
      assign tot_ext = {{(32-PERF_CNTR_WIDTH){1'b0}}, total_cycles_i};
      assign rd_ext  = {{(32-PERF_CNTR_WIDTH){1'b0}}, rd_cycles_i};
      assign pr_ext  = {{(32-PERF_CNTR_WIDTH){1'b0}}, pr_cycles_i};
      assign wr_ext  = {{(32-PERF_CNTR_WIDTH){1'b0}}, wr_cycles_i};
    end
  endgenerate

  // Register map decode; unmapped indices read as zero
  always_comb begin
    rdata_o = 32'd0;
    case (32'(idx_i))
      REG_CTRL:    rdata_o = ctrl_i;
      REG_STATUS:  rdata_o = {28'd0, status_i};
      REG_IRQ:     rdata_o = {31'd0, irq_pend_i};
      REG_TOT_CYC: rdata_o = tot_ext;
      REG_RD_CYC:  rdata_o = rd_ext;
      REG_PR_CYC:  rdata_o = pr_ext;
      REG_WR_CYC:  rdata_o = wr_ext;
      default:     rdata_o = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave_regs.sv
// ============================================================================
// Module      : axi_slave_regs
// Description : AXI4-Lite slave register file for the accelerator host port.
//               CTRL (RW, bit0 write issues tx_req pulse), STATUS, perf
//               counters. Optional interrupt block under macro
//               AXI_SLAVE_IRQ_EN (adds irq port and W1C IRQ_PEND at idx 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_slave_regs
  import axi_slave_pkg::*;
#(
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_ADDR_WIDTH = 6
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  output logic                         tx_req,
  input  logic                         tx_done,
  input  logic                         rd_done,
  input  logic                         wr_done,
  input  logic                         processing_done,
  input  logic [PERF_CNTR_WIDTH-1:0]   total_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   rd_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   pr_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   wr_cycles,
  input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [AXIS_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [AXIS_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY
`ifdef AXI_SLAVE_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int IDX_W  = AXIS_ADDR_WIDTH - 2;
  localparam int STRB_W = AXIS_DATA_WIDTH / 8;

  wr_state_e                  wr_state_q, wr_state_d;
  rd_state_e                  rd_state_q, rd_state_d;
  logic [IDX_W-1:0]           wr_idx_q;
  logic [AXIS_DATA_WIDTH-1:0] wr_data_q;
  logic [STRB_W-1:0]          wr_strb_q;
  logic [IDX_W-1:0]           rd_idx_q;
  logic [AXIS_DATA_WIDTH-1:0] rdata_q;
  logic [AXIS_DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                       tx_req_q, tx_req_d;
  logic [31:0]                mux_rdata;
  logic                       irq_pend_rd;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Both channels must be valid together; the write commits in W_ACK
  logic wr_accept, wr_commit, rd_accept;
  assign wr_accept = (wr_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_commit = (wr_state_q == W_ACK);
  assign rd_accept = (rd_state_q == R_IDLE) && S_AXI_ARVALID;

  // Write FSM next-state: accept -> handshake cycle -> hold response
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (wr_accept) wr_state_d = W_ACK;
      W_ACK:   wr_state_d = W_RESP;
      W_RESP:  if (S_AXI_BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM next-state: accept -> capture cycle -> hold data
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (rd_accept) rd_state_d = R_ACK;
      R_ACK:   rd_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // CTRL byte-masked update and start pulse generation on commit
  always_comb begin
    ctrl_d   = ctrl_q;
    tx_req_d = 1'b0;
    if (wr_commit && (32'(wr_idx_q) == REG_CTRL)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb_q[b]) ctrl_d[8*b +: 8] = wr_data_q[8*b +: 8];
      end
      tx_req_d = wr_strb_q[0] & wr_data_q[0];
    end
  end

  // State, captured request and register storage
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rd_idx_q   <= '0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      tx_req_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      ctrl_q     <= ctrl_d;
      tx_req_q   <= tx_req_d;
      if (wr_accept) begin
        wr_idx_q  <= S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2];
        wr_data_q <= S_AXI_WDATA;
        wr_strb_q <= S_AXI_WSTRB;
      end
      if (rd_accept) rd_idx_q <= S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2];
      if (rd_state_q == R_ACK) rdata_q <= mux_rdata;
    end
  end

`ifdef AXI_SLAVE_IRQ_EN
  logic pdone_q, irq_pend_q, irq_pend_d, irq_q;

  // Sticky pending flag: W1C clear, a same-cycle rising edge wins
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (wr_commit && (32'(wr_idx_q) == REG_IRQ) && wr_strb_q[0] && wr_data_q[0])
      irq_pend_d = 1'b0;
    if (processing_done && !pdone_q)
      irq_pend_d = 1'b1;
  end

  // Edge detector, pending flag and registered interrupt output
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pdone_q    <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pdone_q    <= processing_done;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_pend_d & ctrl_d[1];
    end
  end

  assign irq         = irq_q;
  assign irq_pend_rd = irq_pend_q;
`else
  assign irq_pend_rd = 1'b0;
`endif

  axi_slave_rd_mux #(
    .PERF_CNTR_WIDTH (PERF_CNTR_WIDTH),
    .IDX_W           (IDX_W)
  ) u_rd_mux (
    .idx_i          (rd_idx_q),
    .ctrl_i         (ctrl_q[31:0]),
    .status_i       ({processing_done, wr_done, rd_done, tx_done}),
    .irq_pend_i     (irq_pend_rd),
    .total_cycles_i (total_cycles),
    .rd_cycles_i    (rd_cycles),
    .pr_cycles_i    (pr_cycles),
    .wr_cycles_i    (wr_cycles),
    .rdata_o        (mux_rdata)
  );

  assign S_AXI_AWREADY = (wr_state_q == W_ACK);
  assign S_AXI_WREADY  = (wr_state_q == W_ACK);
  assign S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = (rd_state_q == R_ACK);
  assign S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign tx_req        = tx_req_q;

endmodule

`default_nettype wire
